// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: default widths and FSM state encoding shared by the mac_array_sequencer slice
package mac_seq_pkg;
  localparam int CH_W_DEF      = 64;
  localparam int RES_W_DEF     = 16;
  localparam int LEN_W_DEF     = 8;
  localparam int DRAIN_CYC_DEF = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, CAPTURE, OUT} state_e;
endpackage

// File: rtl/mac_array_sequencer_if.sv
// mac_array_sequencer_if: command, DMA beat and result handshakes of the sequencer
interface mac_array_sequencer_if import mac_seq_pkg::*; #(
  parameter int CH_W  = CH_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [RES_W-1:0] cmd_bias;
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_ch0;
  logic [CH_W-1:0]  in_ch1;
  logic [CH_W-1:0]  in_ch2;
  logic [CH_W-1:0]  in_ch3;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  modport master (
    output cmd_valid, cmd_len, cmd_bias, in_valid, in_ch0, in_ch1, in_ch2, in_ch3, res_ready,
    input  cmd_ready, in_ready, res_valid, res_data
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_bias, in_valid, in_ch0, in_ch1, in_ch2, in_ch3, res_ready,
    output cmd_ready, in_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_counter.sv
// mac_seq_counter: loadable down-counter whose done flag marks the final count
module mac_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d  = load_i ? val_i : cnt_q - W'(dec_i);
  assign cnt_o  = cnt_q;
  assign done_o = cnt_q == W'(1);
  // Count register; a load wins over a decrement
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: job controller feeding one MAC array; MAC_SEQ_RELU_EN clamps negative results to 0
module mac_array_sequencer import mac_seq_pkg::*; #(
  parameter int CH_W      = CH_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_array_sequencer_if.slave bus,
  output logic [CH_W-1:0]      mac_ch0_o,
  output logic [CH_W-1:0]      mac_ch1_o,
  output logic [CH_W-1:0]      mac_ch2_o,
  output logic [CH_W-1:0]      mac_ch3_o,
  output logic                 mac_en_o,
  output logic                 mac_clr_o,
  output logic                 mac_read_en_o,
  output logic [RES_W-1:0]     mac_bias_o,
  input  logic [RES_W-1:0]     mac_dot_i,
  output logic                 busy_o
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_e                 state_q, state_d;
  logic                   cmd_ready_q, in_ready_q, busy_q, mac_en_q, mac_clr_q, read_en_q, res_valid_q;
  logic                   read_en_d;
  logic [3:0][CH_W-1:0]   ch_q;
  logic [RES_W-1:0]       bias_q, res_q, res_cap;
  logic                   take_cmd, beat, res_hs, drain_load;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   beat_last;
  logic [DW-1:0]          drain_cnt;
  logic                   drain_last;
  assign take_cmd   = cmd_ready_q & bus.cmd_valid;
  assign beat       = in_ready_q & bus.in_valid;
  assign res_hs     = res_valid_q & bus.res_ready;
  assign drain_load = state_d == DRAIN && state_q != DRAIN;
  // read_en must land on the last DRAIN cycle, so it is armed one cycle ahead
  assign read_en_d  = state_d == DRAIN && (drain_load ? DRAIN_CYC == 1 : drain_cnt == DW'(2));
  mac_seq_counter #(.W(LEN_W)) u_beat (
    .clk(clk), .rst(rst), .load_i(take_cmd), .val_i(bus.cmd_len), .dec_i(beat),
    .cnt_o(beat_cnt), .done_o(beat_last)
  );
  mac_seq_counter #(.W(DW)) u_drain (
    .clk(clk), .rst(rst), .load_i(drain_load), .val_i(DW'(DRAIN_CYC)), .dec_i(state_q == DRAIN),
    .cnt_o(drain_cnt), .done_o(drain_last)
  );
`ifdef MAC_SEQ_RELU_EN
  assign res_cap = mac_dot_i[RES_W-1] ? '0 : mac_dot_i;
`else
  assign res_cap = mac_dot_i;
`endif
  // Next-state decode of the job sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = take_cmd ? CLEAR : IDLE;
      CLEAR:   state_d = beat_cnt == '0 ? DRAIN : STREAM;
      STREAM:  state_d = beat && beat_last ? DRAIN : STREAM;
      DRAIN:   state_d = drain_last ? CAPTURE : DRAIN;
      CAPTURE: state_d = OUT;
      OUT:     state_d = res_hs ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  // State register with control outputs registered from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      read_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= state_d == IDLE;
      in_ready_q  <= state_d == STREAM;
      busy_q      <= state_d != IDLE;
      mac_clr_q   <= state_d == CLEAR;
      mac_en_q    <= beat;
      read_en_q   <= read_en_d;
      res_valid_q <= state_d == OUT;
    end
  // Beat, bias and result holding registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch_q   <= '0;
      bias_q <= '0;
      res_q  <= '0;
    end else begin
      if (beat) ch_q <= {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0};
      if (take_cmd) bias_q <= bus.cmd_bias;
      if (state_q == CAPTURE) res_q <= res_cap;
    end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_q;
  assign mac_ch0_o     = ch_q[0];
  assign mac_ch1_o     = ch_q[1];
  assign mac_ch2_o     = ch_q[2];
  assign mac_ch3_o     = ch_q[3];
  assign mac_en_o      = mac_en_q;
  assign mac_clr_o     = mac_clr_q;
  assign mac_read_en_o = read_en_q;
  assign mac_bias_o    = bias_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb_mac_array_sequencer: randomized jobs checked against a latency/beat-queue/result reference model
module tb_mac_array_sequencer;
  localparam int DRAIN = 4;
  typedef struct {
    int          lat;
    int          nbub;
    int          unst;
    logic [15:0] res;
    logic [15:0] bias;
    bit          idle;
  } job_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] mac_ch0, mac_ch1, mac_ch2, mac_ch3;
  logic        mac_en, mac_clr, mac_rd, busy;
  logic [15:0] mac_bias;
  logic [15:0] mac_dot = 16'h0;
  logic [15:0] job_dot = 16'h0;
  logic [255:0] exp_q[$];
  logic [255:0] got_q[$];
  int checks = 0, fails = 0;
  int en_cnt = 0, clr_cnt = 0, rd_cnt = 0, ovl_cnt = 0, ir_cnt = 0;
  bit fix_beat = 1'b0;
  int chain_len = 0;
  logic [15:0] chain_bias = 16'h0;
  always #5 clk = ~clk;
  mac_array_sequencer_if #(.CH_W(64), .RES_W(16), .LEN_W(8)) bus ();
  mac_array_sequencer #(.CH_W(64), .RES_W(16), .LEN_W(8), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mac_ch0_o(mac_ch0), .mac_ch1_o(mac_ch1), .mac_ch2_o(mac_ch2), .mac_ch3_o(mac_ch3),
    .mac_en_o(mac_en), .mac_clr_o(mac_clr), .mac_read_en_o(mac_rd), .mac_bias_o(mac_bias),
    .mac_dot_i(mac_dot), .busy_o(busy)
  );
  wire [294:0] outs = {bus.cmd_ready, bus.in_ready, bus.res_valid, bus.res_data, mac_ch3, mac_ch2,
                       mac_ch1, mac_ch0, mac_en, mac_clr, mac_rd, mac_bias, busy};
  // Observed array-side traffic, sampled away from the clock edge
  always @(negedge clk)
    if (!rst) begin
      if (mac_en) begin
        got_q.push_back({mac_ch3, mac_ch2, mac_ch1, mac_ch0});
        en_cnt++;
      end
      clr_cnt += int'(mac_clr);
      rd_cnt  += int'(mac_rd);
      ovl_cnt += int'(mac_en & mac_clr);
      ir_cnt  += int'(bus.in_ready);
    end
  // Array model: clear scrambles the output, read strobe publishes the job's dot product
  always @(posedge clk)
    if (mac_clr) mac_dot <= ~job_dot;
    else if (mac_rd) mac_dot <= job_dot;

  function automatic logic [15:0] ref_res(input logic [15:0] d);
`ifdef MAC_SEQ_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  function automatic int beat_errs();
    int bad = 0;
    if (got_q.size() != exp_q.size()) return 1 + got_q.size() + exp_q.size();
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic clr_mon();
    exp_q.delete();
    got_q.delete();
    en_cnt = 0; clr_cnt = 0; rd_cnt = 0; ovl_cnt = 0; ir_cnt = 0;
  endtask

  // bub<0 selects a fixed pattern: one bubble before beat 2 and one before beat 3
  task automatic run_job(input int len, input logic [15:0] bias, input logic [15:0] dot, input int bub,
                         input int hold, input bit chain, input bit pre, output job_t r);
    int n, k, sent;
    logic [255:0] beat;
    bit stall;
    r.lat = -1; r.nbub = 0; r.unst = 0; r.res = 'x; r.bias = 'x; r.idle = 1'b0;
    sent = 0;
    clr_mon();
    job_dot = dot;
    if (!pre) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'(len); bus.cmd_bias = bias;
      k = 0;
      while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (n < 1200 && !bus.res_valid) begin
      beat = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (bus.in_ready && sent < len) begin
        stall = bub < 0 ? ((sent == 1 && r.nbub == 0) || (sent == 2 && r.nbub == 1))
                        : (int'($urandom_range(99)) < bub);
        if (stall) begin
          bus.in_valid = 1'b0;
          r.nbub++;
        end else begin
          if (fix_beat) beat = 256'd1;
          {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0} = beat;
          bus.in_valid = 1'b1;
          exp_q.push_back(beat);
          sent++;
        end
      end else begin
        {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0} = beat;
        bus.in_valid = 1'($urandom_range(1));
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    if (bus.res_valid) begin
      r.lat = n; r.res = bus.res_data; r.bias = mac_bias;
    end
    if (chain) begin
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'(chain_len); bus.cmd_bias = chain_bias;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== r.res || bus.cmd_ready !== 1'b0 || busy !== 1'b1) r.unst++;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    r.idle = bus.res_valid === 1'b0 && bus.cmd_ready === 1'b1 && busy === 1'b0;
  endtask

  task automatic test_reset();
    job_t r;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1/0", bus.cmd_ready, busy);
    end
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd5; bus.cmd_bias = 16'h1234;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stream_entry: in_ready=%b expected 1", bus.in_ready); end
    bus.in_valid = 1'b1;
    {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0} = {4{64'hDEAD_BEEF_0BAD_F00D}};
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin fails++; $display("FAIL reset_mid_stream: got %h expected 0", outs); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job(3, 16'h0ABC, 16'h1357, 0, 0, 1'b0, 1'b0, r);
    checks++;
    if (r.lat != 3 + r.nbub + DRAIN + 3 || en_cnt != 3 || beat_errs() != 0 || r.res !== ref_res(16'h1357)) begin
      fails++; $display("FAIL post_reset_job: lat=%0d en=%0d res=%h expected lat=%0d en=3 res=%h",
                        r.lat, en_cnt, r.res, 3 + r.nbub + DRAIN + 3, ref_res(16'h1357));
    end
  endtask

  task automatic test_single_beat();
    job_t r;
    fix_beat = 1'b1;
    run_job(1, 16'h0000, 16'h00A5, 0, 0, 1'b0, 1'b0, r);
    fix_beat = 1'b0;
    checks++;
    if (r.lat != 8) begin fails++; $display("FAIL single_latency: got %0d expected 8", r.lat); end
    checks++;
    if (en_cnt != 1 || clr_cnt != 1 || got_q.size() != 1) begin
      fails++; $display("FAIL single_pulses: en=%0d clr=%0d expected 1/1", en_cnt, clr_cnt);
    end else begin
      checks++;
      if (got_q[0] !== 256'd1) begin fails++; $display("FAIL single_beat: got %h expected 1", got_q[0]); end
    end
  endtask

  task automatic test_bubbles();
    job_t r;
    run_job(4, 16'h0011, 16'h7777, -1, 0, 1'b0, 1'b0, r);
    checks++;
    if (r.lat != 4 + 2 + DRAIN + 3 || r.nbub != 2) begin
      fails++; $display("FAIL bubble_latency: got %0d (bubbles %0d) expected %0d", r.lat, r.nbub, 13);
    end
    checks++;
    if (en_cnt != 4 || beat_errs() != 0) begin
      fails++; $display("FAIL bubble_beats: en=%0d errs=%0d expected 4/0", en_cnt, beat_errs());
    end
  endtask

  task automatic test_bias_only();
    job_t r;
    run_job(0, 16'h3C00, 16'h4455, 0, 0, 1'b0, 1'b0, r);
    checks++;
    if (ir_cnt != 0 || en_cnt != 0 || rd_cnt != 1 || clr_cnt != 1) begin
      fails++; $display("FAIL bias_only_ctl: in_ready=%0d en=%0d rd=%0d clr=%0d expected 0/0/1/1",
                        ir_cnt, en_cnt, rd_cnt, clr_cnt);
    end
    checks++;
    if (r.lat != DRAIN + 3 || r.res !== ref_res(16'h4455) || r.bias !== 16'h3C00) begin
      fails++; $display("FAIL bias_only_res: lat=%0d res=%h bias=%h expected %0d/%h/3c00",
                        r.lat, r.res, r.bias, DRAIN + 3, ref_res(16'h4455));
    end
  endtask

  task automatic test_backpressure();
    job_t r;
    chain_len = 2; chain_bias = 16'h0F0F;
    run_job(3, 16'h5555, 16'h2222, 0, 10, 1'b1, 1'b0, r);
    checks++;
    if (r.unst != 0) begin fails++; $display("FAIL hold_stable: %0d unstable cycles expected 0", r.unst); end
    checks++;
    if (!r.idle || r.res !== ref_res(16'h2222)) begin
      fails++; $display("FAIL hold_release: idle=%0b res=%h expected 1/%h", r.idle, r.res, ref_res(16'h2222));
    end
    run_job(2, 16'h0F0F, 16'h0BAD, 0, 0, 1'b0, 1'b1, r);
    checks++;
    if (r.lat != 2 + r.nbub + DRAIN + 3 || r.bias !== 16'h0F0F || r.res !== ref_res(16'h0BAD)) begin
      fails++; $display("FAIL chained_job: lat=%0d bias=%h res=%h expected %0d/0f0f/%h",
                        r.lat, r.bias, r.res, 2 + r.nbub + DRAIN + 3, ref_res(16'h0BAD));
    end
  endtask

  task automatic test_relu();
    job_t r;
    run_job(1, 16'h0000, 16'hBC00, 0, 0, 1'b0, 1'b0, r);
    checks++;
    if (r.res !== ref_res(16'hBC00)) begin fails++; $display("FAIL relu_neg: got %h expected %h", r.res, ref_res(16'hBC00)); end
    run_job(2, 16'h0000, 16'h3C00, 0, 0, 1'b0, 1'b0, r);
    checks++;
    if (r.res !== 16'h3C00) begin fails++; $display("FAIL relu_pos: got %h expected 3c00", r.res); end
  endtask

  task automatic test_random();
    job_t r;
    int len;
    logic [15:0] dot, bias;
    for (int j = 0; j < 16; j++) begin
      len  = j == 0 ? 255 : int'($urandom_range(12));
      dot  = 16'($urandom());
      bias = 16'($urandom());
      run_job(len, bias, dot, int'($urandom_range(40)), int'($urandom_range(3)), 1'b0, 1'b0, r);
      checks++;
      if (r.lat != len + r.nbub + DRAIN + 3) begin
        fails++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", j, r.lat, len + r.nbub + DRAIN + 3);
      end
      checks++;
      if (en_cnt != len || beat_errs() != 0) begin
        fails++; $display("FAIL rand_beats[%0d]: en=%0d errs=%0d expected %0d/0", j, en_cnt, beat_errs(), len);
      end
      checks++;
      if (r.res !== ref_res(dot) || r.bias !== bias) begin
        fails++; $display("FAIL rand_result[%0d]: res=%h bias=%h expected %h/%h", j, r.res, r.bias, ref_res(dot), bias);
      end
      checks++;
      if (clr_cnt != 1 || rd_cnt != 1 || ovl_cnt != 0 || r.unst != 0 || !r.idle) begin
        fails++; $display("FAIL rand_ctl[%0d]: clr=%0d rd=%0d ovl=%0d unst=%0d idle=%0b expected 1/1/0/0/1",
                          j, clr_cnt, rd_cnt, ovl_cnt, r.unst, r.idle);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_bias = '0;
    bus.in_valid = 1'b0; bus.in_ch0 = '0; bus.in_ch1 = '0; bus.in_ch2 = '0; bus.in_ch3 = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_bubbles();
    test_bias_only();
    test_backpressure();
    test_relu();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
